// File: rtl/serial_adder_n.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, LSB first, carry held in a register.
// One-cycle done pulse; sum/carry/overflow update only on the completing edge.
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int CW = $clog2(N + 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder_n: DIGIT must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d, sum_q;
    logic             cy_q, carry_q, ovf_q, busy_q, done_q;
    logic [CW-1:0]    cnt_q;

    logic [DIGIT-1:0] slice_sum;
    logic             slice_co;
    logic             msb_cin;

    // One DIGIT-bit slice; on the last slice its top bit is the operand MSB,
    // so the carry into that bit is recovered from the sum bit.
    always_comb begin
        {slice_co, slice_sum} = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                              + (DIGIT+1)'(cy_q);
        msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_sum[DIGIT-1];
        res_d   = (res_q >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        cy_q    <= sub;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    cy_q  <= slice_co;
                    res_q <= res_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        sum_q   <= res_d;
                        carry_q <= slice_co;
                        ovf_q   <= msb_cin ^ slice_co;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder_n.sv
// Scoreboard bench for serial_adder_n: three geometries (8/1, 8/4, 4/2),
// expected results queued at start and compared when done pulses.
module tb_serial_adder_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] res;
        int          t;
    } exp_t;

    exp_t q8[$], q84[$], q42[$];
    exp_t e8, e84, e42;

    logic       start8 = 0, sub8 = 0, busy8, done8, carry8, ovf8;
    logic [7:0] a8 = 0, b8 = 0, sum8;
    logic       start84 = 0, sub84 = 0, busy84, done84, carry84, ovf84;
    logic [7:0] a84 = 0, b84 = 0, sum84;
    logic       start42 = 0, sub42 = 0, busy42, done42, carry42, ovf42;
    logic [3:0] a42 = 0, b42 = 0, sum42;

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) u_add8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .overflow(ovf8));
    serial_adder_n #(.WIDTH(8), .DIGIT(4)) u_add84 (
        .clk(clk), .rst(rst), .start(start84), .sub(sub84), .a(a84), .b(b84),
        .busy(busy84), .done(done84), .sum(sum84), .carry(carry84), .overflow(ovf84));
    serial_adder_n #(.WIDTH(4), .DIGIT(2)) u_add42 (
        .clk(clk), .rst(rst), .start(start42), .sub(sub42), .a(a42), .b(b42),
        .busy(busy42), .done(done42), .sum(sum42), .carry(carry42), .overflow(ovf42));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference packed as {overflow, carry, sum}, from whole-word arithmetic.
    function automatic logic [31:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                          input logic sv);
        logic [31:0] mask, bb, full, low;
        logic        cout, cin;
        mask = (32'd1 << w) - 32'd1;
        bb   = sv ? (~bv & mask) : (bv & mask);
        full = (av & mask) + bb + 32'(sv);
        low  = (av & (mask >> 1)) + (bb & (mask >> 1)) + 32'(sv);
        cout = full[w];
        cin  = low[w-1];
        return (32'(cout ^ cin) << (w + 1)) | (32'(cout) << w) | (full & mask);
    endfunction

    always @(negedge clk) if (done8) begin
        if (q8.size() == 0) check_eq("spurious_done8", 32'(done8), 0);
        else begin
            e8 = q8.pop_front();
            $display("[8/1] cyc=%0d result={ovf,c,sum}=0x%0h", cyc, {ovf8, carry8, sum8});
            check_eq("res8", 32'({ovf8, carry8, sum8}), e8.res);
            check_eq("lat8", 32'(cyc - e8.t), 8);
        end
    end
    always @(negedge clk) if (done84) begin
        if (q84.size() == 0) check_eq("spurious_done84", 32'(done84), 0);
        else begin
            e84 = q84.pop_front();
            $display("[8/4] cyc=%0d result={ovf,c,sum}=0x%0h", cyc, {ovf84, carry84, sum84});
            check_eq("res84", 32'({ovf84, carry84, sum84}), e84.res);
            check_eq("lat84", 32'(cyc - e84.t), 2);
        end
    end
    always @(negedge clk) if (done42) begin
        if (q42.size() == 0) check_eq("spurious_done42", 32'(done42), 0);
        else begin
            e42 = q42.pop_front();
            $display("[4/2] cyc=%0d result={ovf,c,sum}=0x%0h", cyc, {ovf42, carry42, sum42});
            check_eq("res42", 32'({ovf42, carry42, sum42}), e42.res);
            check_eq("lat42", 32'(cyc - e42.t), 2);
        end
    end

    task automatic wait_done8();
        int i = 0;
        while (!done8 && i < 40) begin @(negedge clk); i++; end
        check_eq("timeout8", 32'(done8), 1);
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic sv);
        @(negedge clk);
        a8 = av; b8 = bv; sub8 = sv; start8 = 1;
        q8.push_back('{model(8, 32'(av), 32'(bv), sv), cyc + 1});
        @(negedge clk);
        start8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        wait_done8();
    endtask

    task automatic op84(input logic [7:0] av, input logic [7:0] bv, input logic sv);
        int i = 0;
        @(negedge clk);
        a84 = av; b84 = bv; sub84 = sv; start84 = 1;
        q84.push_back('{model(8, 32'(av), 32'(bv), sv), cyc + 1});
        @(negedge clk);
        start84 = 0; a84 = 8'($urandom); b84 = 8'($urandom);
        while (!done84 && i < 40) begin @(negedge clk); i++; end
        check_eq("timeout84", 32'(done84), 1);
    endtask

    task automatic op42(input logic [3:0] av, input logic [3:0] bv, input logic sv);
        int i = 0;
        @(negedge clk);
        a42 = av; b42 = bv; sub42 = sv; start42 = 1;
        q42.push_back('{model(4, 32'(av), 32'(bv), sv), cyc + 1});
        @(negedge clk);
        start42 = 0; a42 = 4'($urandom); b42 = 4'($urandom);
        while (!done42 && i < 40) begin @(negedge clk); i++; end
        check_eq("timeout42", 32'(done42), 1);
    endtask

    initial begin
        int nbusy;
        int i;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy8), 0);
        check_eq("rst_done", 32'(done8), 0);
        check_eq("rst_outs", 32'({ovf8, carry8, sum8}), 0);
        rst = 0;

        op8(8'h0F, 8'h01, 0); check_eq("add_0f_01", 32'({ovf8, carry8, sum8}), 32'h010);
        op8(8'hFF, 8'h01, 0); check_eq("add_ff_01", 32'({ovf8, carry8, sum8}), 32'h100);
        op8(8'h7F, 8'h01, 0); check_eq("add_7f_01", 32'({ovf8, carry8, sum8}), 32'h280);
        op8(8'h05, 8'h07, 1); check_eq("sub_05_07", 32'({ovf8, carry8, sum8}), 32'h0FE);
        op8(8'h80, 8'h01, 1); check_eq("sub_80_01", 32'({ovf8, carry8, sum8}), 32'h37F);
        repeat (3) @(negedge clk);
        check_eq("sum_held", 32'(sum8), 32'h7F);

        // Start pulses during RUN must not disturb the operation in flight.
        @(negedge clk);
        a8 = 8'h21; b8 = 8'h13; sub8 = 0; start8 = 1;
        q8.push_back('{model(8, 32'h21, 32'h13, 0), cyc + 1});
        @(negedge clk);
        start8 = 0; nbusy = 0; i = 0;
        while (!done8 && i < 40) begin
            if (busy8) nbusy++;
            start8 = (i == 2 || i == 5);
            a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
            @(negedge clk); i++;
        end
        start8 = 0;
        check_eq("timeout_ign", 32'(done8), 1);
        check_eq("busy_cycles", 32'(nbusy), 8);
        check_eq("ign_result", 32'({ovf8, carry8, sum8}), 32'h034);
        repeat (12) @(negedge clk);

        // Start held through DONE: second operation launches back-to-back.
        @(negedge clk);
        a8 = 8'h40; b8 = 8'h40; sub8 = 0; start8 = 1;
        q8.push_back('{model(8, 32'h40, 32'h40, 0), cyc + 1});
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h05; sub8 = 1;
        wait_done8();
        q8.push_back('{model(8, 32'h03, 32'h05, 1), cyc + 1});
        @(negedge clk);
        start8 = 0;
        wait_done8();
        check_eq("b2b_second", 32'({ovf8, carry8, sum8}), 32'h0FE);

        // Asynchronous reset in the middle of RUN aborts the operation.
        @(negedge clk);
        a8 = 8'hC3; b8 = 8'h5A; sub8 = 0; start8 = 1;
        @(negedge clk);
        start8 = 0;
        repeat (3) @(negedge clk);
        #2 rst = 1;
        #1;
        check_eq("abort_busy", 32'(busy8), 0);
        check_eq("abort_outs", 32'({done8, ovf8, carry8, sum8}), 0);
        @(negedge clk);
        rst = 0;
        repeat (14) @(negedge clk);
        op8(8'h12, 8'h34, 0); check_eq("post_rst", 32'({ovf8, carry8, sum8}), 32'h046);

        for (int k = 0; k < 20; k++) op8(8'($urandom), 8'($urandom), 1'($urandom));

        op84(8'h0F, 8'h01, 0);
        op84(8'h80, 8'h01, 1);
        for (int k = 0; k < 30; k++) op84(8'($urandom), 8'($urandom), 1'($urandom));

        for (int av = 0; av < 16; av++)
            for (int bv = 0; bv < 16; bv++)
                for (int sv = 0; sv < 2; sv++)
                    op42(4'(av), 4'(bv), 1'(sv));

        repeat (5) @(negedge clk);
        check_eq("q8_empty", 32'(q8.size()), 0);
        check_eq("q84_empty", 32'(q84.size()), 0);
        check_eq("q42_empty", 32'(q42.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end
endmodule
